store_part_buffer: RTL and testbench
====================================

# store_part_buffer

Store-side counterpart of the load part-word extractor in the MEM stage. Takes SB/SH/SW requests from the pipeline, replicates store data across byte lanes, and generates byte enables from the address offset. Queues aligned stores in a small FIFO and drains them to data memory over a req/ack handshake. Stalls the pipeline when the FIFO is full and flags misaligned stores instead of writing them.

## Interface
- DATA_WIDTH, 32, data bus width; only 32 is supported, so there are 4 byte lanes.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH, 2, number of FIFO entries; must be at least 2 and a power of two.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MemWriteM  in  1  store request valid this cycle.
- StoreSrcM  in  3  store width (RISC-V funct3): 000 SB, 001 SH, 010 SW; any other code is ignored.
- ALUResultM  in  ADDR_WIDTH  byte address.
- WriteDataM  in  DATA_WIDTH  store data, right-aligned.
- StallStoreM  out  1  FIFO full; pipeline must hold the MEM-stage store.
- MisalignedM  out  1  registered one-cycle pulse: a misaligned store was dropped.
- StoreEmptyM  out  1  FIFO empty and no request outstanding (used for fence/drain).
- MemReq  out  1  memory write request.
- MemAddr  out  ADDR_WIDTH  word-aligned address, {addr[ADDR_WIDTH-1:2], 2'b00}.
- MemWData  out  DATA_WIDTH  lane-replicated data.
- MemBE  out  DATA_WIDTH/8  byte enables.
- MemAck  in  1  memory accepted the current request.

## Operation
- Lane alignment, with off = addr[1:0]:
  - SB: data = {4{wd[7:0]}}, BE = 4'b0001 << off.
  - SH: data = {2{wd[15:0]}}, BE = 4'b0011 << (2*off[1]).
  - SW: data = wd, BE = 4'b1111.
- Misaligned cases:
  - SH is misaligned when off[0] = 1.
  - SW is misaligned when off != 0.
- Accept condition: MemWriteM & legal code & aligned & !full.
  - An accepted store writes {MemAddr, data, BE} into the entry at the write pointer.
- Misaligned condition: MemWriteM & misaligned & !full.
  - The store is not enqueued.
  - MisalignedM goes high in the next cycle, for exactly one cycle.
  - While full, a misaligned request is not flagged; it is flagged once the FIFO has room.
- Illegal StoreSrcM codes are a no-op: nothing is enqueued and nothing is flagged.
- StallStoreM = full, where full means count == DEPTH. Stall does not depend on MemAck; there is no combinational ack-to-stall path.
- Drain side:
  - MemReq = (count != 0).
  - MemAddr, MemWData and MemBE show the head entry while MemReq is high, and are forced to 0 while the FIFO is empty.
  - When MemReq & MemAck at an edge, the head is popped.
  - MemAck is ignored while MemReq is low.
- Count update when a push and a pop happen in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits wide.
- StoreEmptyM = (count == 0).

## Timing
- Reset (asynchronous assert, synchronous release), including reset in the middle of operation:
  - count, read pointer and write pointer go to 0.
  - MemReq = 0, MemBE = 0, MemAddr = 0, MemWData = 0, MisalignedM = 0, StallStoreM = 0, StoreEmptyM = 1.
  - Buffered stores are discarded.
- Latency: a store accepted at edge N has MemReq high during cycle N+1.
- Handshake:
  - The head stays stable until acked.
  - An ack at edge N makes the next entry (if any) visible during cycle N+1, so back-to-back drains proceed at one per cycle under continuous MemAck.
- Full boundary:
  - Cycle with count == DEPTH and MemAck = 1: the pop happens, the push is refused (the stall was already high), and the stall drops in the next cycle.
- Empty boundary:
  - No read-through: a store pushed into an empty FIFO is never presented in the same cycle.

## Structure
- Package store_pkg contains:
  - enum store_op_e: SB = 3'b000, SH = 3'b001, SW = 3'b010.
  - struct store_entry_t holding addr, data and be.
  - localparam NUM_LANES = DATA_WIDTH/8.
- Sub-module store_align (combinational). Inputs: op, addr[1:0], wd. Outputs: data, be, misaligned, legal.
- The FIFO, pointers and handshake are implemented in store_part_buffer.

## Test plan
- Byte lanes: SB to 0x103 with wd = 0x000000AB, MemAck = 1 → next cycle MemReq = 1, MemAddr = 0x100, MemWData = 0xABABABAB, MemBE = 4'b1000.
- Halfword and word:
  - SH to 0x202 with wd = 0x1234 → MemWData = 0x12341234, MemBE = 4'b1100.
  - SW to 0x300 with wd = 0xDEADBEEF → MemBE = 4'b1111.
- Misaligned: SW to 0x301 → no MemReq, MisalignedM high for exactly one cycle, count stays 0. SH to 0x201 gives the same result.
- Full and stall:
  - MemAck held 0, three SB requests in consecutive cycles → StallStoreM high after the second accept, and the third request is held.
  - Raise MemAck → the third store is accepted once the stall clears, and all three drain in order.
- Simultaneous push and pop: count = 1, MemAck = 1 and a new SW in the same cycle → count stays 1, the new entry is presented the next cycle, and there is no bubble.
- Reset mid-stream: two entries queued, assert rst_n = 0 asynchronously between edges → MemReq drops immediately, StoreEmptyM = 1, and nothing is emitted after release.

Source files
------------

// File: rtl/store_pkg.sv
// Shared types and constants for the MEM-stage store buffer.
// Covers the store width codes, the buffered entry layout and the lane count.
package store_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 32;
   localparam int NUM_LANES  = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } store_op_e;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic [NUM_LANES-1:0]  be;
   } store_entry_t;

endpackage

// File: rtl/store_align.sv
// Combinational lane aligner: replicates store data across byte lanes and
// derives byte enables plus legality/alignment flags from the width code.
module store_align
   import store_pkg::*;
(
   input  logic [2:0]            op,
   input  logic [1:0]            addr,
   input  logic [DATA_WIDTH-1:0] wd,
   output logic [DATA_WIDTH-1:0] data,
   output logic [NUM_LANES-1:0]  be,
   output logic                  misaligned,
   output logic                  legal
);

   // Misaligned is only meaningful for recognised codes; unknown codes are silent no-ops.
   always_comb begin
      data       = '0;
      be         = '0;
      misaligned = 1'b0;
      legal      = 1'b0;
      case (op)
         SB: begin
            legal = 1'b1;
            data  = {4{wd[7:0]}};
            be    = 4'b0001 << addr;
         end
         SH: begin
            legal      = 1'b1;
            misaligned = addr[0];
            data       = {2{wd[15:0]}};
            be         = addr[1] ? 4'b1100 : 4'b0011;
         end
         SW: begin
            legal      = 1'b1;
            misaligned = (addr != 2'b00);
            data       = wd;
            be         = 4'b1111;
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/store_part_buffer.sv
// MEM-stage store buffer: aligns SB/SH/SW stores, queues them in a small FIFO
// and drains them to data memory over a req/ack handshake.
module store_part_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    MemWriteM,
   input  logic [2:0]              StoreSrcM,
   input  logic [ADDR_WIDTH-1:0]   ALUResultM,
   input  logic [DATA_WIDTH-1:0]   WriteDataM,
   output logic                    StallStoreM,
   output logic                    MisalignedM,
   output logic                    StoreEmptyM,
   output logic                    MemReq,
   output logic [ADDR_WIDTH-1:0]   MemAddr,
   output logic [DATA_WIDTH-1:0]   MemWData,
   output logic [DATA_WIDTH/8-1:0] MemBE,
   input  logic                    MemAck
);

   import store_pkg::store_entry_t;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [CNT_W-1:0]      count;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   store_entry_t          entries [DEPTH];
   store_entry_t          new_entry;
   store_entry_t          head;

   logic [DATA_WIDTH-1:0]   al_data;
   logic [DATA_WIDTH/8-1:0] al_be;
   logic                    al_misaligned;
   logic                    al_legal;

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic mis_event;

   store_align u_align (
      .op         (StoreSrcM),
      .addr       (ALUResultM[1:0]),
      .wd         (WriteDataM),
      .data       (al_data),
      .be         (al_be),
      .misaligned (al_misaligned),
      .legal      (al_legal)
   );

   // Push/pop decisions depend only on registered count, so ack never reaches stall.
   always_comb begin
      full      = (count == CNT_W'(DEPTH));
      empty     = (count == '0);
      push      = MemWriteM & al_legal & ~al_misaligned & ~full;
      pop       = ~empty & MemAck;
      mis_event = MemWriteM & al_legal & al_misaligned & ~full;

      new_entry      = '0;
      new_entry.addr = {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
      new_entry.data = al_data;
      new_entry.be   = al_be;
   end

   // Occupancy and pointers; a simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: empty entries are never presented on the bus.
   always_ff @(posedge clk) begin
      if (push) begin
         entries[wr_ptr] <= new_entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         MisalignedM <= 1'b0;
      end else begin
         MisalignedM <= mis_event;
      end
   end

   // Bus outputs show the head entry only while a request is outstanding.
   always_comb begin
      head        = entries[rd_ptr];
      MemReq      = ~empty;
      StallStoreM = full;
      StoreEmptyM = empty;
      MemAddr     = '0;
      MemWData    = '0;
      MemBE       = '0;
      if (!empty) begin
         MemAddr  = head.addr;
         MemWData = head.data;
         MemBE    = head.be;
      end
   end

endmodule

// File: tb/tb_store_part_buffer.sv
// Self-checking bench for store_part_buffer: a per-cycle reference queue
// tracks expected FIFO contents, plus directed checks for the key scenarios.
module tb_store_part_buffer;

   import store_pkg::*;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst_n;
   logic        MemWriteM;
   logic [2:0]  StoreSrcM;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic        StallStoreM;
   logic        MisalignedM;
   logic        StoreEmptyM;
   logic        MemReq;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [3:0]  MemBE;
   logic        MemAck;

   int checks = 0;
   int errors = 0;

   store_entry_t expQ[$];
   bit           expMis = 1'b0;

   store_part_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .MemWriteM   (MemWriteM),
      .StoreSrcM   (StoreSrcM),
      .ALUResultM  (ALUResultM),
      .WriteDataM  (WriteDataM),
      .StallStoreM (StallStoreM),
      .MisalignedM (MisalignedM),
      .StoreEmptyM (StoreEmptyM),
      .MemReq      (MemReq),
      .MemAddr     (MemAddr),
      .MemWData    (MemWData),
      .MemBE       (MemBE),
      .MemAck      (MemAck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit we, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wd, input bit ack);
      @(posedge clk);
      #1;
      MemWriteM  = we;
      StoreSrcM  = op;
      ALUResultM = addr;
      WriteDataM = wd;
      MemAck     = ack;
   endtask

   // Independent alignment model written per lane rather than by shifting.
   function automatic void expEntry(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                                    output store_entry_t e, output bit legal, output bit mis);
      int off;
      off    = int'(addr[1:0]);
      e      = '0;
      e.addr = addr & 32'hFFFF_FFFC;
      legal  = 1'b1;
      mis    = 1'b0;
      case (op)
         3'b000: begin
            for (int i = 0; i < 4; i++) e.data[8*i +: 8] = wd[7:0];
            e.be[off] = 1'b1;
         end
         3'b001: begin
            mis    = addr[0];
            e.data = {wd[15:0], wd[15:0]};
            e.be   = (off >= 2) ? 4'b1100 : 4'b0011;
         end
         3'b010: begin
            mis    = (off != 0);
            e.data = wd;
            e.be   = 4'b1111;
         end
         default: legal = 1'b0;
      endcase
   endfunction

   // Scoreboard: compare outputs against the reference queue, then advance it
   // with the inputs that will be sampled at the coming rising edge.
   always @(negedge clk) begin
      store_entry_t e;
      bit           legal;
      bit           mis;
      bit           doPush;
      bit           doPop;
      if (!rst_n) begin
         expQ.delete();
         expMis = 1'b0;
         checkOutput("rst_req", MemReq, 0);
         checkOutput("rst_empty", StoreEmptyM, 1);
         checkOutput("rst_stall", StallStoreM, 0);
         checkOutput("rst_mis", MisalignedM, 0);
         checkOutput("rst_be", MemBE, 0);
         checkOutput("rst_addr", MemAddr, 0);
         checkOutput("rst_wdata", MemWData, 0);
      end else begin
         checkOutput("sb_stall", StallStoreM, expQ.size() == DEPTH);
         checkOutput("sb_empty", StoreEmptyM, expQ.size() == 0);
         checkOutput("sb_req", MemReq, expQ.size() != 0);
         checkOutput("sb_mis", MisalignedM, expMis);
         if (expQ.size() == 0) begin
            checkOutput("idle_bus", {MemAddr, MemWData}, 64'h0);
            checkOutput("idle_be", MemBE, 0);
         end else begin
            checkOutput("head_addr", MemAddr, expQ[0].addr);
            checkOutput("head_data", MemWData, expQ[0].data);
            checkOutput("head_be", MemBE, expQ[0].be);
         end
         expEntry(StoreSrcM, ALUResultM, WriteDataM, e, legal, mis);
         doPush = MemWriteM && legal && !mis && (expQ.size() != DEPTH);
         doPop  = (expQ.size() != 0) && MemAck;
         expMis = MemWriteM && legal && mis && (expQ.size() != DEPTH);
         if (doPop)  void'(expQ.pop_front());
         if (doPush) expQ.push_back(e);
      end
   end

   initial begin
      rst_n      = 1'b0;
      MemWriteM  = 1'b0;
      StoreSrcM  = 3'b000;
      ALUResultM = '0;
      WriteDataM = '0;
      MemAck     = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Byte store into the top lane
      applyStimulus(1, 3'b000, 32'h103, 32'h0000_00AB, 1);
      applyStimulus(0, 3'b000, 32'h0, 32'h0, 1);
      @(negedge clk);
      checkOutput("sb_req", MemReq, 1);
      checkOutput("sb_addr", MemAddr, 32'h100);
      checkOutput("sb_data", MemWData, 32'hABAB_ABAB);
      checkOutput("sb_be", MemBE, 4'b1000);

      // Upper halfword
      applyStimulus(1, 3'b001, 32'h202, 32'h0000_1234, 1);
      applyStimulus(0, 3'b000, 32'h0, 32'h0, 1);
      @(negedge clk);
      checkOutput("sh_data", MemWData, 32'h1234_1234);
      checkOutput("sh_be", MemBE, 4'b1100);

      // Full word
      applyStimulus(1, 3'b010, 32'h300, 32'hDEAD_BEEF, 1);
      applyStimulus(0, 3'b000, 32'h0, 32'h0, 1);
      @(negedge clk);
      checkOutput("sw_data", MemWData, 32'hDEAD_BEEF);
      checkOutput("sw_be", MemBE, 4'b1111);

      // Misaligned word, then misaligned halfword
      applyStimulus(1, 3'b010, 32'h301, 32'h1111_1111, 1);
      applyStimulus(0, 3'b000, 32'h0, 32'h0, 1);
      @(negedge clk);
      checkOutput("misw_pulse", MisalignedM, 1);
      checkOutput("misw_req", MemReq, 0);
      checkOutput("misw_empty", StoreEmptyM, 1);
      applyStimulus(0, 3'b000, 32'h0, 32'h0, 1);
      @(negedge clk);
      checkOutput("misw_one", MisalignedM, 0);
      applyStimulus(1, 3'b001, 32'h201, 32'h2222, 1);
      applyStimulus(0, 3'b000, 32'h0, 32'h0, 1);
      @(negedge clk);
      checkOutput("mish_pulse", MisalignedM, 1);
      checkOutput("mish_req", MemReq, 0);
      applyStimulus(0, 3'b000, 32'h0, 32'h0, 1);
      @(negedge clk);
      checkOutput("mish_one", MisalignedM, 0);

      // Illegal width code is a silent no-op
      applyStimulus(1, 3'b011, 32'h400, 32'h3333_3333, 1);
      applyStimulus(0, 3'b000, 32'h0, 32'h0, 1);
      @(negedge clk);
      checkOutput("ill_req", MemReq, 0);
      checkOutput("ill_mis", MisalignedM, 0);

      // Fill with ack low, hold the third store, then release ack
      applyStimulus(1, 3'b000, 32'h500, 32'h11, 0);
      applyStimulus(1, 3'b000, 32'h501, 32'h22, 0);
      applyStimulus(1, 3'b000, 32'h502, 32'h33, 0);
      @(negedge clk);
      checkOutput("full_stall", StallStoreM, 1);
      checkOutput("full_head_be", MemBE, 4'b0001);
      applyStimulus(1, 3'b000, 32'h502, 32'h33, 0);
      @(negedge clk);
      checkOutput("full_hold", StallStoreM, 1);
      applyStimulus(1, 3'b000, 32'h502, 32'h33, 1);
      @(negedge clk);
      checkOutput("full_ack_stall", StallStoreM, 1);
      applyStimulus(1, 3'b000, 32'h502, 32'h33, 1);
      @(negedge clk);
      checkOutput("full_drop", StallStoreM, 0);
      checkOutput("full_second_be", MemBE, 4'b0010);
      applyStimulus(0, 3'b000, 32'h0, 32'h0, 1);
      @(negedge clk);
      checkOutput("full_third_be", MemBE, 4'b0100);
      checkOutput("full_third_data", MemWData, 32'h3333_3333);
      applyStimulus(0, 3'b000, 32'h0, 32'h0, 1);

      // Push and pop in the same cycle with one entry queued
      applyStimulus(1, 3'b010, 32'h600, 32'h0101_0101, 1);
      applyStimulus(1, 3'b010, 32'h604, 32'hCAFE_F00D, 1);
      @(negedge clk);
      checkOutput("pp_first", MemAddr, 32'h600);
      applyStimulus(0, 3'b000, 32'h0, 32'h0, 1);
      @(negedge clk);
      checkOutput("pp_req", MemReq, 1);
      checkOutput("pp_addr", MemAddr, 32'h604);
      checkOutput("pp_data", MemWData, 32'hCAFE_F00D);
      applyStimulus(0, 3'b000, 32'h0, 32'h0, 1);

      // Reset mid-stream with two entries queued
      applyStimulus(1, 3'b010, 32'h700, 32'h7777_0000, 0);
      applyStimulus(1, 3'b010, 32'h704, 32'h7777_0004, 0);
      applyStimulus(0, 3'b000, 32'h0, 32'h0, 0);
      @(negedge clk);
      checkOutput("mid_pre_stall", StallStoreM, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid_req", MemReq, 0);
      checkOutput("mid_empty", StoreEmptyM, 1);
      checkOutput("mid_be", MemBE, 0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 3'b000, 32'h0, 32'h0, 1);
         @(negedge clk);
         checkOutput("post_rst_req", MemReq, 0);
      end

      applyStimulus(0, 3'b000, 32'h0, 32'h0, 1);
      @(negedge clk);
      #1;
      checkOutput("sb_drained", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
